// File: rtl/mac_accumulator_8bit.sv
// Multiply-accumulate stage: streams 8x8 products into a dot-product sum.
// Define MAC_SAT_EN to saturate on overflow; otherwise the accumulator wraps.

module wallace_multiplier_8bit_by_8bit (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    logic [15:0] pp [8];
    logic [15:0] s0, c0, s1, c1, s2, c2;
    logic [15:0] s3, c3, s4, c4, s5, c5;

    // 3:2 compressor over whole rows; carries move one column left
    function automatic logic [31:0] csa(
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [15:0] z
    );
        logic [15:0] s;
        logic [15:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {c, s};
    endfunction

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pp[i] = {8'd0, a & {8{b[i]}}} << i;
        end
        {c0, s0} = csa(pp[0], pp[1], pp[2]);
        {c1, s1} = csa(pp[3], pp[4], pp[5]);
        {c2, s2} = csa(s0, c0, s1);
        {c3, s3} = csa(c1, pp[6], pp[7]);
        {c4, s4} = csa(s2, c2, s3);
        {c5, s5} = csa(s4, c4, c3);
        p = s5 + c5;
    end

endmodule

module mac_accumulator_8bit #(
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 255,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [1:0] ACCUM = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]       state;
    logic [15:0]      prod;
    logic [15:0]      p_reg;
    logic             p_vld;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             accept;
    logic             close;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] acc_next;

    wallace_multiplier_8bit_by_8bit mul (
        .a (in_a),
        .b (in_b),
        .p (prod)
    );

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;

    assign accept = in_valid & in_ready;
    assign close  = accept & (in_last | ((int'(cnt) + 1) == MAX_TERMS));

    assign sum_ext = {1'b0, acc} + (ACC_W + 1)'(p_reg);
    assign carry   = sum_ext[ACC_W];

`ifdef MAC_SAT_EN
    // Once pinned at full scale every later add carries again, so it stays
    assign acc_next = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_next = sum_ext[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            p_reg <= '0;
            p_vld <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            if (p_vld) begin
                acc <= acc_next;
                if (carry) begin
                    ovf <= 1'b1;
                end
            end
            p_vld <= accept;
            if (accept) begin
                p_reg <= prod;
                cnt   <= cnt + CNT_W'(1);
            end
            case (state)
                ACCUM: begin
                    if (close) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: state <= HOLD;
                HOLD: begin
                    if (out_ready) begin
                        state <= ACCUM;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                        p_vld <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator_8bit.sv
// Randomized and directed bench for mac_accumulator_8bit against a
// vector-level sum/count/overflow reference model.

module tb_mac_accumulator_8bit;

    localparam int ACC_W     = 17;
    localparam int MAX_TERMS = 4;
    localparam int CNT_W     = $clog2(MAX_TERMS + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_a = '0;
    logic [7:0]       in_b = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    always #5 clk = ~clk;

    mac_accumulator_8bit #(
        .ACC_W     (ACC_W),
        .MAX_TERMS (MAX_TERMS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    typedef struct {
        int a;
        int b;
        bit last;
        int gap;
    } term_t;

    typedef struct {
        longint sum;
        int     cnt;
        bit     ovf;
    } res_t;

    term_t  tq[$];
    longint hs_sum[$];
    int     hs_cnt[$];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    bit     pend = 0;
    res_t   exp_r;
    int     close_cyc = 0;
    longint m_total = 0;
    int     m_cnt = 0;
    int     ready_pct = 100;
    int     hold_n = 0;
    int     hold_cnt = 0;
    bit     rst_drain = 0;
    bit     post_rst = 0;
    bit     acc_flag = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic add(input int a, input int b, input bit last,
                       input int gap);
        term_t t;
        t.a = a;
        t.b = b;
        t.last = last;
        t.gap = gap;
        tq.push_back(t);
    endtask

    task automatic model_close();
        longint lim;
        lim = longint'(1) << ACC_W;
        exp_r.cnt = m_cnt;
        exp_r.ovf = (m_total >= lim);
`ifdef MAC_SAT_EN
        exp_r.sum = exp_r.ovf ? lim - 1 : m_total;
`else
        exp_r.sum = m_total % lim;
`endif
        pend = 1;
        close_cyc = cyc;
        m_total = 0;
        m_cnt = 0;
    endtask

    task automatic run(input int budget);
        int n;
        bit rdy;
        n = 0;
        while ((tq.size() != 0 || pend || in_valid) && n < budget) begin
            @(negedge clk);
            cyc++;
            n++;
            rst = 1'b0;
            chk("in_ready", 32'(in_ready), 32'(!pend));
            chk("out_valid", 32'(out_valid),
                32'(pend && cyc >= close_cyc + 2));
            if (post_rst) begin
                chk("rst_sum", 32'(out_sum), 0);
                chk("rst_count", 32'(out_count), 0);
                chk("rst_ovf", 32'(out_ovf), 0);
                post_rst = 0;
            end
            if (out_valid && pend) begin
                chk("out_sum", 32'(out_sum), 32'(exp_r.sum));
                chk("out_count", 32'(out_count), 32'(exp_r.cnt));
                chk("out_ovf", 32'(out_ovf), 32'(exp_r.ovf));
            end
            rdy = !pend;
            out_ready = 1'b0;
            if (out_valid) begin
                if (hold_cnt < hold_n) hold_cnt++;
                else out_ready = ($urandom_range(99) < ready_pct);
            end
            if (out_valid && out_ready && pend) begin
                hs_sum.push_back(longint'(out_sum));
                hs_cnt.push_back(int'(out_count));
                pend = 0;
                hold_cnt = 0;
            end
            if (rst_drain && pend && cyc == close_cyc + 1) begin
                rst = 1'b1;
                pend = 0;
                rst_drain = 0;
                post_rst = 1;
                in_valid = 1'b0;
                acc_flag = 0;
                continue;
            end
            if (acc_flag) begin
                in_valid = 1'b0;
                acc_flag = 0;
            end
            if (!in_valid) begin
                in_a = 8'($urandom);
                in_b = 8'($urandom);
                in_last = 1'($urandom);
                if (tq.size() != 0) begin
                    if (tq[0].gap > 0) begin
                        tq[0].gap--;
                    end else begin
                        in_valid = 1'b1;
                        in_a = 8'(tq[0].a);
                        in_b = 8'(tq[0].b);
                        in_last = tq[0].last;
                        void'(tq.pop_front());
                    end
                end
            end
            if (in_valid && rdy) begin
                m_total += longint'(in_a) * longint'(in_b);
                m_cnt++;
                acc_flag = 1;
                if (in_last || m_cnt == MAX_TERMS) model_close();
            end
        end
        if (n >= budget) chk("timeout", 1, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_sum", 32'(out_sum), 0);
        chk("reset_count", 32'(out_count), 0);
        chk("reset_ovf", 32'(out_ovf), 0);

        add(5, 3, 0, 0);
        add(91, 44, 0, 0);
        add(205, 186, 0, 0);
        add(255, 254, 1, 0);
        hs_sum.delete();
        hs_cnt.delete();
        run(60);
        chk("dot4_n", hs_sum.size(), 1);
        if (hs_sum.size() == 1) begin
            chk("dot4_sum", 32'(hs_sum[0]), 106919);
            chk("dot4_cnt", 32'(hs_cnt[0]), 4);
        end

        add(205, 186, 0, 0);
        add(255, 254, 0, 0);
        add(255, 254, 1, 0);
        hs_sum.delete();
        run(60);
        if (hs_sum.size() == 1) begin
`ifdef MAC_SAT_EN
            chk("ovf_sum", 32'(hs_sum[0]), 131071);
`else
            chk("ovf_sum", 32'(hs_sum[0]), 36598);
`endif
        end else begin
            chk("ovf_n", hs_sum.size(), 1);
        end

        hold_n = 5;
        add(255, 255, 1, 0);
        add(2, 3, 1, 0);
        hs_sum.delete();
        run(60);
        hold_n = 0;
        chk("bp_n", hs_sum.size(), 2);
        if (hs_sum.size() == 2) begin
            chk("bp_sum0", 32'(hs_sum[0]), 65025);
            chk("bp_sum1", 32'(hs_sum[1]), 6);
        end

        for (int i = 0; i < 6; i++) add(1, 1, i == 5, 0);
        hs_sum.delete();
        hs_cnt.delete();
        run(60);
        chk("auto_n", hs_sum.size(), 2);
        if (hs_sum.size() == 2) begin
            chk("auto_sum", 32'(hs_sum[0]), 4);
            chk("auto_cnt", 32'(hs_cnt[0]), 4);
            chk("auto_next", 32'(hs_cnt[1]), 2);
        end

        rst_drain = 1;
        add(10, 10, 0, 0);
        add(20, 20, 1, 0);
        add(3, 7, 1, 0);
        hs_sum.delete();
        hs_cnt.delete();
        run(60);
        chk("rstv_n", hs_sum.size(), 1);
        if (hs_sum.size() == 1) begin
            chk("rstv_sum", 32'(hs_sum[0]), 21);
            chk("rstv_cnt", 32'(hs_cnt[0]), 1);
        end

        add(2, 2, 0, 0);
        add(4, 4, 1, 3);
        hs_sum.delete();
        hs_cnt.delete();
        run(60);
        if (hs_sum.size() == 1) begin
            chk("gap_sum", 32'(hs_sum[0]), 20);
            chk("gap_cnt", 32'(hs_cnt[0]), 2);
        end else begin
            chk("gap_n", hs_sum.size(), 1);
        end

        ready_pct = 60;
        for (int v = 0; v < 40; v++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                int a;
                int b;
                a = ($urandom_range(3) == 0) ? 255 : $urandom_range(255);
                b = ($urandom_range(3) == 0) ? 255 : $urandom_range(255);
                add(a, b, (k == len - 1) || ($urandom_range(5) == 0),
                    ($urandom_range(3) == 0) ? $urandom_range(1, 2) : 0);
            end
        end
        run(4000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
